// File: rtl/issue_dispatch.sv
// Dual-issue dispatch stage: picks 0, 1 or 2 instructions from the issue
// buffer head, checks load-use and intra-pair hazards, and registers the
// chosen pair into the EX stage. Also counts issued instructions and bubbles.
//
// Instruction set layout (53 bits, MSB..LSB):
//   [52:21] pc, [20:16] rf_raddr2, [15:11] rf_raddr1, [10:6] rf_rd,
//   [5:3] br_type, [2] mem_we, [1] wb_sel, [0] rf_we
module issue_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic [52:0] i_PC_set1,
    input  logic [52:0] i_PC_set2,
    input  logic [1:0]  i_is_valid,
    input  logic        flush_BR,
    input  logic        stall_DCache,
    output logic [1:0]  o_usingNUM,
    output logic [52:0] o_EX_set1,
    output logic [52:0] o_EX_set2,
    output logic [1:0]  o_EX_valid,
    output logic        o_bubble,
    output logic [31:0] o_issue_cnt,
    output logic [31:0] o_bubble_cnt
);

    localparam int RA2_LSB = 16;
    localparam int RA1_LSB = 11;
    localparam int RD_LSB  = 6;
    localparam int BR_LSB  = 3;
    localparam int MEMWE_B = 2;
    localparam int WBSEL_B = 1;
    localparam int RFWE_B  = 0;

    function automatic logic [4:0] f_rd(input logic [52:0] s);
        return s[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_ra1(input logic [52:0] s);
        return s[RA1_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_ra2(input logic [52:0] s);
        return s[RA2_LSB +: 5];
    endfunction

    function automatic logic is_mem(input logic [52:0] s);
        return s[WBSEL_B] | s[MEMWE_B];
    endfunction

    function automatic logic writes_rd(input logic [52:0] s);
        return s[RFWE_B] && (f_rd(s) != 5'd0);
    endfunction

    // True when producer p is a valid load whose destination feeds a source of c.
    function automatic logic load_hit(input logic [52:0] p, input logic pv,
                                      input logic [52:0] c);
        return pv && p[WBSEL_B] && writes_rd(p) &&
               ((f_rd(p) == f_ra1(c)) || (f_rd(p) == f_ra2(c)));
    endfunction

    logic haz_a;
    logic haz_b;
    logic raw_pair;
    logic mem_pair;
    logic br_a;
    logic waw_pair;
    logic issue_a;
    logic issue_b;
    logic normal_edge;

    // Hazard detection against the current EX registers and within the pair.
    always_comb begin
        haz_a    = load_hit(o_EX_set1, o_EX_valid[1], i_PC_set1) |
                   load_hit(o_EX_set2, o_EX_valid[0], i_PC_set1);
        haz_b    = load_hit(o_EX_set1, o_EX_valid[1], i_PC_set2) |
                   load_hit(o_EX_set2, o_EX_valid[0], i_PC_set2);
        raw_pair = writes_rd(i_PC_set1) &&
                   ((f_rd(i_PC_set1) == f_ra1(i_PC_set2)) ||
                    (f_rd(i_PC_set1) == f_ra2(i_PC_set2)));
        mem_pair = is_mem(i_PC_set1) & is_mem(i_PC_set2);
        br_a     = (i_PC_set1[BR_LSB +: 3] != 3'd0);
        waw_pair = writes_rd(i_PC_set1) && writes_rd(i_PC_set2) &&
                   (f_rd(i_PC_set1) == f_rd(i_PC_set2));
        issue_a  = i_is_valid[1] & ~haz_a;
        issue_b  = issue_a & i_is_valid[0] & ~haz_b & ~raw_pair &
                   ~mem_pair & ~br_a & ~waw_pair;
    end

    // Consumption count and bubble flag back to the issue buffer.
    always_comb begin
        normal_edge = ~flush_BR & ~stall_DCache;
        o_usingNUM  = 2'b00;
        if (normal_edge) begin
            if (issue_b) begin
                o_usingNUM = 2'b10;
            end else if (issue_a) begin
                o_usingNUM = 2'b01;
            end
        end
        o_bubble = i_is_valid[1] & ~issue_a & normal_edge;
    end

    // EX stage registers: flush kills valids, stall holds, otherwise load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_EX_set1  <= '0;
            o_EX_set2  <= '0;
            o_EX_valid <= 2'b00;
        end else if (flush_BR) begin
            o_EX_valid <= 2'b00;
        end else if (!stall_DCache) begin
            o_EX_set1  <= i_PC_set1;
            o_EX_set2  <= i_PC_set2;
            o_EX_valid <= {issue_a, issue_b};
        end
    end

    // Performance counters; both wrap naturally and hold on flush or stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_issue_cnt  <= 32'd0;
            o_bubble_cnt <= 32'd0;
        end else if (normal_edge) begin
            o_issue_cnt  <= o_issue_cnt + {30'd0, o_usingNUM};
            if (o_bubble) begin
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed testbench for issue_dispatch with hand-computed expectations.
module tb_issue_dispatch;

    logic        clk;
    logic        rst;
    logic [52:0] i_PC_set1;
    logic [52:0] i_PC_set2;
    logic [1:0]  i_is_valid;
    logic        flush_BR;
    logic        stall_DCache;
    logic [1:0]  o_usingNUM;
    logic [52:0] o_EX_set1;
    logic [52:0] o_EX_set2;
    logic [1:0]  o_EX_valid;
    logic        o_bubble;
    logic [31:0] o_issue_cnt;
    logic [31:0] o_bubble_cnt;

    int checks;
    int errors;

    logic [52:0] ins_a;
    logic [52:0] ins_b;

    issue_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .i_PC_set1    (i_PC_set1),
        .i_PC_set2    (i_PC_set2),
        .i_is_valid   (i_is_valid),
        .flush_BR     (flush_BR),
        .stall_DCache (stall_DCache),
        .o_usingNUM   (o_usingNUM),
        .o_EX_set1    (o_EX_set1),
        .o_EX_set2    (o_EX_set2),
        .o_EX_valid   (o_EX_valid),
        .o_bubble     (o_bubble),
        .o_issue_cnt  (o_issue_cnt),
        .o_bubble_cnt (o_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an instruction set vector from its fields.
    function automatic logic [52:0] mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] ra1, input logic [4:0] ra2,
                                       input logic we, input logic wb,
                                       input logic mw, input logic [2:0] br);
        return {pc, ra2, ra1, rd, br, mw, wb, we};
    endfunction

    task automatic apply_stimulus(input logic [52:0] a, input logic [52:0] b,
                                  input logic [1:0] v, input logic fl,
                                  input logic st);
        i_PC_set1    = a;
        i_PC_set2    = b;
        i_is_valid   = v;
        flush_BR     = fl;
        stall_DCache = st;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        apply_stimulus('0, '0, 2'b00, 1'b0, 1'b0);
        #12;
        check_output("rst_valid", {62'd0, o_EX_valid}, 64'd0);
        check_output("rst_set1", {11'd0, o_EX_set1}, 64'd0);
        check_output("rst_set2", {11'd0, o_EX_set2}, 64'd0);
        check_output("rst_icnt", {32'd0, o_issue_cnt}, 64'd0);
        check_output("rst_bcnt", {32'd0, o_bubble_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Dual independent adds
        ins_a = mk(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        ins_b = mk(32'h104, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        #1;
        check_output("dual_using", {62'd0, o_usingNUM}, 64'd2);
        check_output("dual_bubble", {63'd0, o_bubble}, 64'd0);
        next_edge();
        check_output("dual_exv", {62'd0, o_EX_valid}, 64'd3);
        check_output("dual_icnt", {32'd0, o_issue_cnt}, 64'd2);
        check_output("dual_set1", {11'd0, o_EX_set1}, {11'd0, ins_a});
        check_output("dual_set2", {11'd0, o_EX_set2}, {11'd0, ins_b});

        // RAW inside the pair: A writes r5, B reads r5
        @(negedge clk);
        ins_a = mk(32'h108, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        ins_b = mk(32'h10c, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        #1;
        check_output("raw_using", {62'd0, o_usingNUM}, 64'd1);
        next_edge();
        check_output("raw_exv", {62'd0, o_EX_valid}, 64'd2);
        check_output("raw_icnt", {32'd0, o_issue_cnt}, 64'd3);
        check_output("raw_set2", {11'd0, o_EX_set2}, {11'd0, ins_b});

        // Load r7 into EX pipe A
        @(negedge clk);
        ins_a = mk(32'h110, 5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b10, 1'b0, 1'b0);
        #1;
        check_output("ld_using", {62'd0, o_usingNUM}, 64'd1);
        next_edge();
        check_output("ld_icnt", {32'd0, o_issue_cnt}, 64'd4);

        // Consumer of r7: one bubble
        @(negedge clk);
        ins_a = mk(32'h114, 5'd9, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b10, 1'b0, 1'b0);
        #1;
        check_output("lu_using", {62'd0, o_usingNUM}, 64'd0);
        check_output("lu_bubble", {63'd0, o_bubble}, 64'd1);
        next_edge();
        check_output("lu_exv", {62'd0, o_EX_valid}, 64'd0);
        check_output("lu_bcnt", {32'd0, o_bubble_cnt}, 64'd1);
        check_output("lu_icnt", {32'd0, o_issue_cnt}, 64'd4);
        @(negedge clk);
        #1;
        check_output("lu2_using", {62'd0, o_usingNUM}, 64'd1);
        check_output("lu2_bubble", {63'd0, o_bubble}, 64'd0);
        next_edge();
        check_output("lu2_exv", {62'd0, o_EX_valid}, 64'd2);
        check_output("lu2_icnt", {32'd0, o_issue_cnt}, 64'd5);
        check_output("lu2_bcnt", {32'd0, o_bubble_cnt}, 64'd1);

        // Two loads in the pair
        @(negedge clk);
        ins_a = mk(32'h118, 5'd10, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0);
        ins_b = mk(32'h11c, 5'd11, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        #1;
        check_output("mem_using", {62'd0, o_usingNUM}, 64'd1);
        next_edge();
        check_output("mem_icnt", {32'd0, o_issue_cnt}, 64'd6);

        // Branch in slot A blocks B
        @(negedge clk);
        ins_a = mk(32'h120, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 3'd1);
        ins_b = mk(32'h124, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        #1;
        check_output("br_using", {62'd0, o_usingNUM}, 64'd1);
        next_edge();
        check_output("br_icnt", {32'd0, o_issue_cnt}, 64'd7);

        // Dual issue to reach count 9 with both pipes valid
        @(negedge clk);
        ins_a = mk(32'h128, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        ins_b = mk(32'h12c, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        next_edge();
        check_output("pre_rst_exv", {62'd0, o_EX_valid}, 64'd3);
        check_output("pre_rst_icnt", {32'd0, o_issue_cnt}, 64'd9);

        // Async reset pulse between edges, during a stall and flush
        @(negedge clk);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_output("arst_exv", {62'd0, o_EX_valid}, 64'd0);
        check_output("arst_icnt", {32'd0, o_issue_cnt}, 64'd0);
        check_output("arst_bcnt", {32'd0, o_bubble_cnt}, 64'd0);
        check_output("arst_set1", {11'd0, o_EX_set1}, 64'd0);
        rst = 1'b0;
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        next_edge();
        check_output("post_rst_exv", {62'd0, o_EX_valid}, 64'd3);
        check_output("post_rst_icnt", {32'd0, o_issue_cnt}, 64'd2);

        // WAW: both write r3
        @(negedge clk);
        ins_a = mk(32'h130, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        ins_b = mk(32'h134, 5'd3, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(ins_a, ins_b, 2'b11, 1'b0, 1'b0);
        #1;
        check_output("waw_using", {62'd0, o_usingNUM}, 64'd1);
        next_edge();
        check_output("waw_exv", {62'd0, o_EX_valid}, 64'd2);
        check_output("waw_icnt", {32'd0, o_issue_cnt}, 64'd3);

        // Stall holds EX registers and counters
        @(negedge clk);
        ins_b = mk(32'h13c, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b0, 3'd0);
        apply_stimulus(mk(32'h138, 5'd19, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0),
                       ins_b, 2'b11, 1'b0, 1'b1);
        #1;
        check_output("stall_using", {62'd0, o_usingNUM}, 64'd0);
        next_edge();
        check_output("stall_exv", {62'd0, o_EX_valid}, 64'd2);
        check_output("stall_set1", {11'd0, o_EX_set1}, {11'd0, ins_a});
        check_output("stall_icnt", {32'd0, o_issue_cnt}, 64'd3);

        // Flush together with stall: valids cleared, sets and counters kept
        @(negedge clk);
        apply_stimulus(mk(32'h140, 5'd19, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0),
                       ins_b, 2'b11, 1'b1, 1'b1);
        #1;
        check_output("flush_using", {62'd0, o_usingNUM}, 64'd0);
        check_output("flush_bubble", {63'd0, o_bubble}, 64'd0);
        next_edge();
        check_output("flush_exv", {62'd0, o_EX_valid}, 64'd0);
        check_output("flush_set1", {11'd0, o_EX_set1}, {11'd0, ins_a});
        check_output("flush_icnt", {32'd0, o_issue_cnt}, 64'd3);
        check_output("flush_bcnt", {32'd0, o_bubble_cnt}, 64'd0);

        // B valid without A is ignored
        @(negedge clk);
        apply_stimulus(ins_a, ins_b, 2'b01, 1'b0, 1'b0);
        #1;
        check_output("bonly_using", {62'd0, o_usingNUM}, 64'd0);
        check_output("bonly_bubble", {63'd0, o_bubble}, 64'd0);
        next_edge();
        check_output("bonly_exv", {62'd0, o_EX_valid}, 64'd0);
        check_output("bonly_set2", {11'd0, o_EX_set2}, {11'd0, ins_b});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
